// File: rtl/pwm_duty_ctrl_pkg.sv
// Shared types and constants for the PWM duty controller: FSM encoding,
// duty code type and saturation limits.
package pwm_pkg;

  typedef enum logic [1:0] {MANUAL, RAMP_UP, RAMP_DOWN} duty_state_t;

  typedef logic [3:0] duty_t;

  localparam duty_t DUTY_MAX = 4'd15;
  localparam duty_t DUTY_MIN = 4'd0;

  // Counter width able to hold 0..terminal-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Control bundle between the duty controller and its environment:
// raw buttons and mode select in, registered duty code and flags out.
interface pwm_duty_ctrl_if;
  import pwm_pkg::*;

  logic  btn_up;
  logic  btn_down;
  logic  auto_en;
  duty_t duty_cycle;
  logic  at_max;
  logic  at_min;

  modport master (
    output btn_up, btn_down, auto_en,
    input  duty_cycle, at_max, at_min
  );

  modport slave (
    input  btn_up, btn_down, auto_en,
    output duty_cycle, at_max, at_min
  );

endinterface

// File: rtl/pwm_duty_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each debounced rising edge.
module btn_debounce
  import pwm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic arst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse
);

  localparam int unsigned      CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt;
  logic             sync_level;

  assign sync_level = sync_q[1];

  // NOTE: non-blocking assignments make every flop sample its pre-edge value;
  // blocking ones here would collapse the two synchroniser stages into one.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q      <= '0;
      cnt         <= '0;
      btn_level   <= 1'b0;
      level_d     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      if (sync_level == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        btn_level <= ~btn_level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      level_d     <= btn_level;
      press_pulse <= btn_level & ~level_d;
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-code source for the PWM generator: debounced up/down stepping in
// manual mode, or a 0..15..0 triangle sweep in auto mode.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 200_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned RAMP_MS     = 2
) (
  input logic            clk,
  input logic            arst_n,
  pwm_duty_ctrl_if.slave bus
);

  localparam int unsigned      DEB_CYCLES  = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned      RAMP_CYCLES = CLK_FREQ / 1000 * RAMP_MS;
  localparam int unsigned      RAMP_W      = cnt_width(RAMP_CYCLES);
  localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_CYCLES - 1);

  duty_state_t       state, state_next;
  duty_t             duty_q, duty_next;
  logic              at_max_q, at_min_q;
  logic [RAMP_W-1:0] ramp_cnt;
  logic              ramp_tick;
  logic              up_pulse, down_pulse;
  logic              up_level, down_level;
  logic              unused_levels;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk         (clk),
    .arst_n      (arst_n),
    .btn_raw     (bus.btn_up),
    .btn_level   (up_level),
    .press_pulse (up_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk         (clk),
    .arst_n      (arst_n),
    .btn_raw     (bus.btn_down),
    .btn_level   (down_level),
    .press_pulse (down_pulse)
  );

  // Only the press pulses drive the duty; the levels are left for debug.
  assign unused_levels = up_level ^ down_level;

  assign ramp_tick = (state != MANUAL) && (ramp_cnt == RAMP_LAST);

  // NOTE: defaults first so every path assigns both outputs; a missing
  // assignment in always_comb would otherwise infer a latch.
  always_comb begin
    state_next = state;
    duty_next  = duty_q;
    case (state)
      MANUAL: begin
        if (up_pulse && !down_pulse && duty_q != DUTY_MAX)
          duty_next = duty_q + 4'd1;
        else if (down_pulse && !up_pulse && duty_q != DUTY_MIN)
          duty_next = duty_q - 4'd1;
        if (bus.auto_en) state_next = RAMP_UP;
      end
      RAMP_UP: begin
        if (!bus.auto_en) begin
          state_next = MANUAL;
        end else if (ramp_tick) begin
          if (duty_q != DUTY_MAX) begin
            duty_next = duty_q + 4'd1;
          end else begin
            state_next = RAMP_DOWN;
            duty_next  = duty_q - 4'd1;
          end
        end
      end
      RAMP_DOWN: begin
        if (!bus.auto_en) begin
          state_next = MANUAL;
        end else if (ramp_tick) begin
          if (duty_q != DUTY_MIN) begin
            duty_next = duty_q - 4'd1;
          end else begin
            state_next = RAMP_UP;
            duty_next  = duty_q + 4'd1;
          end
        end
      end
      default: state_next = MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= MANUAL;
      duty_q   <= DUTY_MIN;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
      ramp_cnt <= '0;
    end else begin
      state    <= state_next;
      duty_q   <= duty_next;
      // Flags come from the same next value, so they never lag the duty.
      at_max_q <= (duty_next == DUTY_MAX);
      at_min_q <= (duty_next == DUTY_MIN);
      if (state == MANUAL || ramp_tick) ramp_cnt <= '0;
      else                              ramp_cnt <= ramp_cnt + RAMP_W'(1);
    end
  end

  assign bus.duty_cycle = duty_q;
  assign bus.at_max     = at_max_q;
  assign bus.at_min     = at_min_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl at reduced clock: DEB_CYCLES=8, RAMP_CYCLES=16.
module tb_pwm_duty_ctrl;
  import pwm_pkg::*;

  localparam int DEB  = 8;
  localparam int RAMP = 16;

  logic clk = 1'b0;
  logic arst_n;
  int   n_vec = 0;
  int   n_err = 0;

  pwm_duty_ctrl_if bus_if ();

  pwm_duty_ctrl #(
    .CLK_FREQ    (8000),
    .DEBOUNCE_MS (1),
    .RAMP_MS     (2)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_of(input logic [3:0] d);
    return {d, d == 4'd15, d == 4'd0};
  endfunction

  function automatic logic [5:0] obs();
    return {bus_if.duty_cycle, bus_if.at_max, bus_if.at_min};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_up();
    bus_if.btn_up = 1'b1;
    step(DEB + 4);
    bus_if.btn_up = 1'b0;
    step(DEB + 4);
  endtask

  task automatic press_down();
    bus_if.btn_down = 1'b1;
    step(DEB + 4);
    bus_if.btn_down = 1'b0;
    step(DEB + 4);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    bus_if.btn_up = 1'b0; bus_if.btn_down = 1'b0; bus_if.auto_en = 1'b0;
    #23;
    n_vec++; if (obs() !== exp_of(4'd0)) begin n_err++; $display("FAIL reset_hold got %h want %h", obs(), exp_of(4'd0)); end
    arst_n = 1'b1;
    step(5);
    n_vec++; if (obs() !== exp_of(4'd0)) begin n_err++; $display("FAIL reset_release got %h want %h", obs(), exp_of(4'd0)); end
    bus_if.auto_en = 1'b1;
    step(RAMP * 7 + 1);
    n_vec++; if (obs() !== exp_of(4'd7)) begin n_err++; $display("FAIL ramp_to_7 got %h want %h", obs(), exp_of(4'd7)); end
    #3 arst_n = 1'b0;
    #1;
    n_vec++; if (obs() !== exp_of(4'd0)) begin n_err++; $display("FAIL async_reset got %h want %h", obs(), exp_of(4'd0)); end
    n_vec++; if (dut.state !== MANUAL) begin n_err++; $display("FAIL reset_state got %0d want %0d", dut.state, MANUAL); end
    bus_if.auto_en = 1'b0;
    #10 arst_n = 1'b1;
    step(RAMP + 4);
    n_vec++; if (obs() !== exp_of(4'd0)) begin n_err++; $display("FAIL post_reset_hold got %h want %h", obs(), exp_of(4'd0)); end
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 40; i++) begin
      bus_if.btn_up = ((i / 3) % 2 == 0);
      step(1);
      n_vec++; if (obs() !== exp_of(4'd0)) begin n_err++; $display("FAIL bounce_cycle_%0d got %h want %h", i, obs(), exp_of(4'd0)); end
    end
    bus_if.btn_up = 1'b0;
    step(4);
    bus_if.btn_up = 1'b1;
    step(DEB + 3);
    n_vec++; if (obs() !== exp_of(4'd0)) begin n_err++; $display("FAIL press_latency_early got %h want %h", obs(), exp_of(4'd0)); end
    step(1);
    n_vec++; if (obs() !== exp_of(4'd1)) begin n_err++; $display("FAIL press_latency_exact got %h want %h", obs(), exp_of(4'd1)); end
    bus_if.btn_up = 1'b0;
    step(DEB + 4);
    n_vec++; if (obs() !== exp_of(4'd1)) begin n_err++; $display("FAIL release_no_change got %h want %h", obs(), exp_of(4'd1)); end
  endtask

  task automatic test_simultaneous();
    repeat (4) press_up();
    n_vec++; if (obs() !== exp_of(4'd5)) begin n_err++; $display("FAIL pre_simul got %h want %h", obs(), exp_of(4'd5)); end
    bus_if.btn_up = 1'b1; bus_if.btn_down = 1'b1;
    step(DEB + 4);
    n_vec++; if (obs() !== exp_of(4'd5)) begin n_err++; $display("FAIL simul_press got %h want %h", obs(), exp_of(4'd5)); end
    bus_if.btn_up = 1'b0; bus_if.btn_down = 1'b0;
    step(DEB + 4);
    n_vec++; if (obs() !== exp_of(4'd5)) begin n_err++; $display("FAIL simul_release got %h want %h", obs(), exp_of(4'd5)); end
  endtask

  task automatic test_saturation();
    repeat (9) press_up();
    n_vec++; if (obs() !== exp_of(4'd14)) begin n_err++; $display("FAIL near_max got %h want %h", obs(), exp_of(4'd14)); end
    repeat (11) press_up();
    n_vec++; if (obs() !== exp_of(4'd15)) begin n_err++; $display("FAIL sat_max got %h want %h", obs(), exp_of(4'd15)); end
    repeat (14) press_down();
    n_vec++; if (obs() !== exp_of(4'd1)) begin n_err++; $display("FAIL near_min got %h want %h", obs(), exp_of(4'd1)); end
    repeat (6) press_down();
    n_vec++; if (obs() !== exp_of(4'd0)) begin n_err++; $display("FAIL sat_min got %h want %h", obs(), exp_of(4'd0)); end
    repeat (14) press_up();
    n_vec++; if (obs() !== exp_of(4'd14)) begin n_err++; $display("FAIL climb_to_14 got %h want %h", obs(), exp_of(4'd14)); end
  endtask

  task automatic test_auto_ramp();
    bus_if.auto_en = 1'b1;
    step(RAMP);
    n_vec++; if (obs() !== exp_of(4'd14)) begin n_err++; $display("FAIL ramp_hold got %h want %h", obs(), exp_of(4'd14)); end
    step(1);
    n_vec++; if (obs() !== exp_of(4'd15)) begin n_err++; $display("FAIL ramp_step1 got %h want %h", obs(), exp_of(4'd15)); end
    bus_if.btn_down = 1'b1;
    step(RAMP);
    n_vec++; if (obs() !== exp_of(4'd14)) begin n_err++; $display("FAIL ramp_step2 got %h want %h", obs(), exp_of(4'd14)); end
    bus_if.btn_down = 1'b0; bus_if.btn_up = 1'b1;
    step(RAMP);
    n_vec++; if (obs() !== exp_of(4'd13)) begin n_err++; $display("FAIL ramp_step3 got %h want %h", obs(), exp_of(4'd13)); end
    bus_if.btn_up = 1'b0;
  endtask

  task automatic test_auto_exit();
    step(RAMP * 4);
    n_vec++; if (obs() !== exp_of(4'd9)) begin n_err++; $display("FAIL ramp_to_9 got %h want %h", obs(), exp_of(4'd9)); end
    bus_if.auto_en = 1'b0;
    step(RAMP * 2 + 1);
    n_vec++; if (obs() !== exp_of(4'd9)) begin n_err++; $display("FAIL exit_hold got %h want %h", obs(), exp_of(4'd9)); end
    press_up();
    n_vec++; if (obs() !== exp_of(4'd10)) begin n_err++; $display("FAIL manual_after_exit got %h want %h", obs(), exp_of(4'd10)); end
    bus_if.auto_en = 1'b1;
    step(RAMP);
    n_vec++; if (obs() !== exp_of(4'd10)) begin n_err++; $display("FAIL reentry_hold got %h want %h", obs(), exp_of(4'd10)); end
    step(1);
    n_vec++; if (obs() !== exp_of(4'd11)) begin n_err++; $display("FAIL reentry_step got %h want %h", obs(), exp_of(4'd11)); end
    bus_if.auto_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_simultaneous();
    test_saturation();
    test_auto_ramp();
    test_auto_exit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

- Upstream control stage for the static PWM generator; drives its 4-bit `duty_cycle` input.
- Two modes:
  - Manual: two push buttons are synchronised and debounced; each press steps the duty up or down, saturating at 0 and 15.
  - Auto: the duty sweeps 0→15→0 as a triangle ramp, one step per `RAMP_MS`.
- Output is registered and glitch-free, so the PWM block can sample it on any cycle.

## Interface
Parameters:
- `CLK_FREQ`, 200_000_000: clock frequency in Hz.
- `DEBOUNCE_MS`, 10: input stable time, in ms. `DEB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS`.
- `RAMP_MS`, 2: auto-ramp step period, in ms. `RAMP_CYCLES = CLK_FREQ/1000*RAMP_MS`, which is 400_000 at the default clock.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `arst_n` in 1: asynchronous active-low reset.
- `btn_up` in 1: raw, asynchronous, bouncing push button; active-high.
- `btn_down` in 1: raw, asynchronous, bouncing push button; active-high.
- `auto_en` in 1: level input, synchronous to `clk`. 1 selects auto ramp, 0 selects manual.
- `duty_cycle` out 4: duty code 0..15; connects directly to the PWM generator.
- `at_max` out 1: registered, equals (`duty_cycle` == 15).
- `at_min` out 1: registered, equals (`duty_cycle` == 0).

## Operation
- **Reset values:** `duty_cycle`=0, `at_min`=1, `at_max`=0, state=MANUAL. All synchronisers, debounce counters and the ramp timer are cleared.
- **Reset mid-operation:** asserting `arst_n` at any time forces the reset values immediately (asynchronous).
- **Debounce, per button:**
  - Input passes a 2-flop synchroniser.
  - A counter increments while the synchronised level differs from the debounced level. It clears to 0 whenever they are equal.
  - When the counter reaches `DEB_CYCLES`-1 while the levels still differ, the debounced level toggles and the counter clears.
  - A rising edge of the debounced level produces a one-cycle press pulse. Releases produce nothing.
- **State MANUAL:**
  - `up_pulse` only: `duty_cycle` +1, saturating at 15.
  - `down_pulse` only: `duty_cycle` -1, saturating at 0.
  - Both pulses in the same cycle: no change.
  - Transition to RAMP_UP when `auto_en`=1.
- **State RAMP_UP:**
  - On each ramp tick: if `duty_cycle`<15, increment; otherwise go to RAMP_DOWN and decrement (15→14).
- **State RAMP_DOWN:**
  - On each ramp tick: if `duty_cycle`>0, decrement; otherwise go to RAMP_UP and increment (0→1).
- **Button handling by mode:** in both ramp states, button pulses are ignored and the debouncers keep running.
- **Leaving auto:** `auto_en`=0 in any ramp state returns to MANUAL on the next edge. `duty_cycle` holds its current value.
- **Ramp timer:**
  - Counts 0..`RAMP_CYCLES`-1 and only runs in ramp states.
  - The tick is asserted when the count equals `RAMP_CYCLES`-1; the count then wraps to 0.
  - The timer clears to 0 in MANUAL, so entering auto always restarts a full period.
- **Flags:** `at_max` and `at_min` are registered alongside `duty_cycle` and are never stale.

## Timing
- **Press latency:** `btn_up` is first sampled high at edge k and then held. In order:
  - Synchronised level is high after edge k+1.
  - Debounced level toggles at edge k+1+`DEB_CYCLES`.
  - Press pulse is registered at the next edge.
  - `duty_cycle` updates at edge k+`DEB_CYCLES`+3.
- **Bounce rejection:** a high pulse shorter than `DEB_CYCLES` cycles, measured at the synchroniser output, causes no change.
- **Auto entry:** `auto_en` is sampled 1 at edge e, so the state becomes RAMP_UP at e. The first step occurs at edge e+`RAMP_CYCLES`; later steps follow every `RAMP_CYCLES` edges.
- **Update rate:** `duty_cycle` changes by at most 1 per clock.
- **Width and arithmetic:** all counters are sized with `$clog2` of their terminal count. Duty arithmetic is done on 4 bits with explicit saturation checks; wrap-around never occurs.

## Structure
- **Package `pwm_pkg`:**
  - `typedef enum logic [1:0] {MANUAL, RAMP_UP, RAMP_DOWN} duty_state_t`
  - `DUTY_MAX`=4'd15 and `DUTY_MIN`=4'd0
- **Sub-module `btn_debounce`:**
  - Parameter `DEB_CYCLES`.
  - Ports `clk`, `arst_n`, `btn_raw`, `btn_level`, `press_pulse`.
  - Contains the synchroniser, stability counter and rising-edge detector; instantiated twice.
- **Top level:** holds the FSM, ramp timer and duty register.

## Test plan
Simulation parameters: `CLK_FREQ`=8000, `DEBOUNCE_MS`=1, `RAMP_MS`=2. This gives `DEB_CYCLES`=8 and `RAMP_CYCLES`=16.
1. **Reset:** hold `arst_n`=0, then release → `duty_cycle`=0, `at_min`=1, `at_max`=0. Assert `arst_n`=0 again mid-ramp at duty 7 → immediately 0, MANUAL.
2. **Debounce:** `btn_up` toggles every 3 cycles for 40 cycles, then stays high → no change during the bounce. Duty becomes 1 exactly `DEB_CYCLES`+3 edges after the final stable rise.
3. **Saturation:** 20 clean `btn_up` presses → duty 15, `at_max`=1. 20 clean `btn_down` presses → duty 0 with no underflow.
4. **Simultaneous press:** `btn_up` and `btn_down` rise on the same edge at duty 5 → duty stays 5.
5. **Auto ramp:** set `auto_en`=1 at duty 14 → 15 after 16 cycles, then 14, then 13, each 16 cycles apart. Buttons pressed meanwhile have no effect.
6. **Auto exit:** drop `auto_en` at duty 9 → duty holds 9. A following `btn_up` press gives 10. Re-entering auto gives the first step exactly 16 cycles later.
